gpo_seg_display: RTL and testbench

Downstream display stage for the `soc` general-purpose output port. It takes a 32-bit GPO word, such as the factorial result on `gpO1`, and shows it on an 8-digit multiplexed seven-segment display. The word is shown either as hex or as decimal; decimal conversion is a sequential double-dabble. The display digits update atomically when a conversion completes.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/hex_to_7seg.sv | 32 +++
 rtl/gpo_seg_display.sv | 144 ++++++++++++++
 tb/tb_gpo_seg_display.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the GPO seven-segment display: active-low font,
// special glyphs and the decimal-conversion FSM states.
package seg_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [31:0] MAX_DEC = 32'd99_999_999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-segment decoder; active-low, seg[0] is segment a.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/gpo_seg_display.sv
// Shows a 32-bit GPO word on an 8-digit multiplexed display, in hex or in
// decimal via a sequential double-dabble; digits update atomically.
module gpo_seg_display
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] val,
    input  logic        dec,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        busy,
    output logic [31:0] disp_word,
    output logic [7:0]  blank
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    state_t        state, state_nxt;
    logic [31:0]   val_q;
    logic          dec_q;
    logic [39:0]   bcd, bcd_adj;
    logic [31:0]   sr;
    logic [5:0]    cnt;
    logic          ovf;
    logic          start;
    logic [7:0]    lead_blank;
    logic          zero_run;
    logic [CW-1:0] ref_cnt;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic [6:0]    font;

    assign start = (state == IDLE) && ({val, dec} != {val_q, dec_q});
    assign busy  = (state != IDLE);
    assign nib   = disp_word[{idx, 2'b00} +: 4];

    hex_to_7seg u_font (
        .nibble (nib),
        .seg    (font)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && dec) state_nxt = SHIFT;
            SHIFT:   if (cnt == 6'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digit 0 is never blanked, so the scan stops at digit 1.
    always_comb begin
        lead_blank = '0;
        zero_run   = 1'b1;
        for (int unsigned i = 7; i >= 1; i--) begin
            zero_run      = zero_run && (bcd[4*i +: 4] == 4'd0);
            lead_blank[i] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q     <= '0;
            dec_q     <= 1'b0;
            bcd       <= '0;
            sr        <= '0;
            cnt       <= '0;
            disp_word <= '0;
            blank     <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        val_q <= val;
                        dec_q <= dec;
                        if (!dec) begin
                            disp_word <= val;
                            blank     <= '0;
                            ovf       <= 1'b0;
                        end else begin
                            bcd <= '0;
                            sr  <= val;
                            cnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    {bcd, sr} <= {bcd_adj, sr} << 1;
                    cnt       <= cnt + 6'd1;
                end
                DONE: begin
                    if (val_q > MAX_DEC) begin
                        disp_word <= '1;
                        blank     <= '0;
                        ovf       <= 1'b1;
                    end else begin
                        disp_word <= bcd[31:0];
                        blank     <= lead_blank;
                        ovf       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            an      <= '1;
            seg     <= SEG_BLANK;
        end else begin
            an <= ~(8'b1 << idx);
            if (ovf)             seg <= SEG_DASH;
            else if (blank[idx]) seg <= SEG_BLANK;
            else                 seg <= font;
            if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= idx + 3'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpo_seg_display.sv
// Randomized, model-checked bench for gpo_seg_display with directed
// scenarios for reset, hex, decimal, overflow and mid-conversion events.
module tb_gpo_seg_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] val = '0;
    logic        dec = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        busy;
    logic [31:0] disp_word;
    logic [7:0]  blank;

    int tests  = 0;
    int failed = 0;

    gpo_seg_display #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .val       (val),
        .dec       (dec),
        .an        (an),
        .seg       (seg),
        .busy      (busy),
        .disp_word (disp_word),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    // Lit-segment patterns (1 = on, bit0 = a); the display drives them inverted.
    logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    bit          m_valid = 1'b0;
    logic [7:0]  m_an;
    logic [6:0]  m_seg;
    logic [31:0] m_disp, m_val_q, p_disp;
    logic [7:0]  m_blank, p_blank;
    logic        m_ovf, p_ovf, m_dec_q;
    int          m_rem, m_tick, m_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic decimal_model(input logic [31:0] v, output logic [31:0] d,
                                 output logic [7:0] b, output logic o);
        longint x;
        int     top;
        d = '0; b = '0; o = 1'b0;
        if (v > 32'd99_999_999) begin
            d = '1;
            o = 1'b1;
        end else begin
            x   = longint'(v);
            top = 0;
            for (int i = 0; i < 8; i++) begin
                d[4*i +: 4] = 4'(x % 10);
                if (x % 10 != 0) top = i;
                x = x / 10;
            end
            for (int i = top + 1; i < 8; i++) b[i] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_an = 8'hFF; m_seg = 7'h7F;
            m_disp = '0; m_blank = '0; m_ovf = 1'b0;
            m_val_q = '0; m_dec_q = 1'b0;
            m_rem = 0; m_tick = 0; m_idx = 0;
        end else begin
            m_an = ~(8'd1 << m_idx);
            if (m_ovf)                m_seg = 7'b0111111;
            else if (m_blank[m_idx])  m_seg = 7'h7F;
            else                      m_seg = ~lit[m_disp[4*m_idx +: 4]];
            if (m_tick == DIV - 1) begin
                m_tick = 0;
                m_idx  = (m_idx + 1) % 8;
            end else begin
                m_tick++;
            end
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_disp = p_disp; m_blank = p_blank; m_ovf = p_ovf;
                end
            end else if (val != m_val_q || dec != m_dec_q) begin
                m_val_q = val;
                m_dec_q = dec;
                if (!dec) begin
                    m_disp = val; m_blank = '0; m_ovf = 1'b0;
                end else begin
                    m_rem = 33;
                    decimal_model(val, p_disp, p_blank, p_ovf);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("an", 32'(an), 32'(m_an));
            check("seg", 32'(seg), 32'(m_seg));
            check("busy", 32'(busy), 32'(m_rem > 0));
            check("disp_word", disp_word, m_disp);
            check("blank", 32'(blank), 32'(m_blank));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure_busy(output int hi);
        int n = 0;
        while (!busy && n < 5) begin @(negedge clk); n++; end
        hi = 0;
        while (busy && hi < 100) begin hi++; @(negedge clk); end
    endtask

    initial begin
        int c, hi, lo;
        logic [31:0] rv;

        // Reset
        rst = 1'b1; val = '0; dec = 1'b0;
        tick(2);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_disp", disp_word, 32'h0);
        rst = 1'b0;
        tick(1);
        check("post_rst_an", 32'(an), 32'hFE);
        check("post_rst_busy", 32'(busy), 32'h0);

        // Hex display
        val = 32'h12345678; dec = 1'b0;
        tick(1);
        check("hex_disp", disp_word, 32'h12345678);
        check("hex_blank", 32'(blank), 32'h0);
        check("model_hex", m_disp, 32'h12345678);
        c = 0;
        while (an == 8'hFE && c < 80) begin @(negedge clk); c++; end
        while (an != 8'hFE && c < 80) begin @(negedge clk); c++; end
        check("hex_digit0_seg", 32'(seg), 32'h00);
        c = 0;
        do begin @(negedge clk); c++; end while (an == 8'hFE && c < 80);
        while (an != 8'hFE && c < 80) begin @(negedge clk); c++; end
        check("an_period", 32'(c), 32'd32);

        // Decimal 120
        val = 32'd120; dec = 1'b1;
        measure_busy(hi);
        check("dec120_busy_len", 32'(hi), 32'd33);
        check("dec120_disp", disp_word, 32'h00000120);
        check("dec120_blank", 32'(blank), 32'hF8);
        check("model_dec120", m_disp, 32'h00000120);
        tick(40);

        // Overflow
        val = 32'd100_000_000;
        measure_busy(hi);
        check("ovf_busy_len", 32'(hi), 32'd33);
        check("ovf_disp", disp_word, 32'hFFFFFFFF);
        check("ovf_blank", 32'(blank), 32'h0);
        tick(2);
        check("ovf_seg_dash", 32'(seg), 32'h3F);
        tick(20);

        // Maximum 8-digit value
        val = 32'd99_999_999;
        measure_busy(hi);
        check("max_disp", disp_word, 32'h99999999);
        check("max_blank", 32'(blank), 32'h0);
        tick(10);

        // Input change during conversion is deferred
        val = 32'd120;
        c = 0;
        while (!busy && c < 5) begin @(negedge clk); c++; end
        hi = 1;
        tick(9);
        hi += 9;
        val = 32'd720;
        while (busy && hi < 100) begin @(negedge clk); if (busy) hi++; end
        check("chg_first_len", 32'(hi), 32'd33);
        check("chg_first_disp", disp_word, 32'h00000120);
        lo = 0;
        while (!busy && lo < 10) begin lo++; @(negedge clk); end
        check("chg_busy_low", 32'(lo), 32'd1);
        measure_busy(hi);
        check("chg_second_len", 32'(hi), 32'd33);
        check("chg_second_disp", disp_word, 32'h00000720);
        tick(5);

        // Reset during conversion
        val = 32'd120;
        c = 0;
        while (!busy && c < 5) begin @(negedge clk); c++; end
        tick(15);
        rst = 1'b1;
        tick(2);
        check("mid_rst_disp", disp_word, 32'h0);
        check("mid_rst_an", 32'(an), 32'hFF);
        check("mid_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        measure_busy(hi);
        check("mid_rst_len", 32'(hi), 32'd33);
        check("mid_rst_disp_after", disp_word, 32'h00000120);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = $urandom_range(0, 9999);
                1:       rv = 32'd99_999_990 + $urandom_range(0, 20);
                default: rv = $urandom;
            endcase
            val = rv;
            dec = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1; tick(1); rst = 1'b0;
            end
            tick($urandom_range(1, 50));
        end
        tick(40);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        failed++;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
